// File: rtl/micro_op_queue_pkg.sv
// rtl/micro_op_queue_pkg.sv - micro-op payload layout and queue defaults
// Purpose: shared widths, field offsets and the packed micro-op struct used by
//          the micro-op queue and its lane-compaction helper.
// Ports:   none (package).
package micro_op_queue_pkg;

    localparam int OPC_W = 6;
    localparam int REG_W = 5;
    localparam int IMM_W = 16;
    localparam int PC_W  = 32;

    // Packed micro-op {opcode,rd,rs,rt,imm,bit_mode,efl_mode,pc}, pc in the LSBs.
    localparam int UOP_W = OPC_W + 3 * REG_W + IMM_W + 2 + PC_W;

    localparam int UOP_PC_LSB   = 0;
    localparam int UOP_EFL_BIT  = UOP_PC_LSB + PC_W;
    localparam int UOP_BIT_BIT  = UOP_EFL_BIT + 1;
    localparam int UOP_IMM_LSB  = UOP_BIT_BIT + 1;
    localparam int UOP_RT_LSB   = UOP_IMM_LSB + IMM_W;
    localparam int UOP_RS_LSB   = UOP_RT_LSB + REG_W;
    localparam int UOP_RD_LSB   = UOP_RS_LSB + REG_W;
    localparam int UOP_OPC_LSB  = UOP_RD_LSB + REG_W;

    // Fetch delivers this many micro-op lanes per cycle.
    localparam int MICRO_Q_N = 4;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [IMM_W-1:0] imm;
        logic             bit_mode;
        logic             efl_mode;
        logic [PC_W-1:0]  pc;
    } uop_t;

endpackage

// File: rtl/micro_op_queue_lane_compact.sv
// rtl/micro_op_queue_lane_compact.sv - sparse lane mask to dense slot offsets
// Purpose: combinational prefix-sum over a lane-valid mask. Each lane gets the
//          number of set lanes below it, which is its slot offset from the write
//          pointer. The total popcount is also produced.
// Ports:   lane_valid (in)  per-lane valid, lane 0 oldest
//          slot_off   (out) lane i offset at [i*OFF_W +: OFF_W]
//          n_set      (out) popcount of lane_valid
module micro_op_queue_lane_compact
    import micro_op_queue_pkg::*;
#(
    parameter int LANES = MICRO_Q_N,
    parameter int OFF_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]       lane_valid,
    output logic [LANES*OFF_W-1:0] slot_off,
    output logic [OFF_W-1:0]       n_set
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc      = '0;
        slot_off = '0;
        for (int i = 0; i < LANES; i++) begin
            slot_off[i*OFF_W +: OFF_W] = acc;
            acc = acc + OFF_W'(lane_valid[i]);
        end
        n_set = acc;
    end

endmodule

// File: rtl/micro_op_queue.sv
// rtl/micro_op_queue.sv - multi-lane micro-op queue between fetch and decode
// Purpose: circular queue accepting up to ENQ_W compacted micro-ops per cycle and
//          presenting the DEQ_W oldest entries to a multi-issue decoder, with
//          stall (freeze) and flush (redirect).
// Ports:   clk, rstn (async active-low)
//          flush, stall                     control
//          enq_valid, enq_data, enq_ready   fetch side
//          deq_valid, deq_data, deq_take    decode side
//          count                            occupied entries
//          err                              sticky over-take error
// DEPTH must be a power of two so pointers wrap by natural overflow.
module micro_op_queue
    import micro_op_queue_pkg::*;
#(
    parameter int ENQ_W     = MICRO_Q_N,
    parameter int DEQ_W     = 2,
    parameter int DEPTH     = 16,
    parameter int PAYLOAD_W = UOP_W
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         stall,
    input  logic [ENQ_W-1:0]             enq_valid,
    input  logic [ENQ_W*PAYLOAD_W-1:0]   enq_data,
    output logic                         enq_ready,
    output logic [DEQ_W-1:0]             deq_valid,
    output logic [DEQ_W*PAYLOAD_W-1:0]   deq_data,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_take,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int TAKE_W = $clog2(DEQ_W + 1);
    localparam int OFF_W  = $clog2(ENQ_W + 1);

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [ENQ_W*OFF_W-1:0] slot_off;
    logic [OFF_W-1:0]       n_enq;
    logic [CNT_W-1:0]       free_slots;
    logic [TAKE_W-1:0]      n_avail;
    logic [TAKE_W-1:0]      n_deq;
    logic                   over_take;
    logic                   enq_fire;
    logic                   deq_fire;

    micro_op_queue_lane_compact #(
        .LANES (ENQ_W),
        .OFF_W (OFF_W)
    ) u_compact (
        .lane_valid (enq_valid),
        .slot_off   (slot_off),
        .n_set      (n_enq)
    );

    // Readiness is judged on pre-dequeue occupancy so it depends on registers only.
    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign enq_ready  = free_slots >= CNT_W'(ENQ_W);
    assign count      = count_q;
    assign err        = err_q;

    assign n_avail   = (count_q >= CNT_W'(DEQ_W)) ? TAKE_W'(DEQ_W) : TAKE_W'(count_q);
    assign over_take = deq_take > n_avail;
    assign n_deq     = over_take ? n_avail : deq_take;

    assign enq_fire = enq_ready && (|enq_valid) && !stall && !flush;
    assign deq_fire = (deq_take != '0) && !stall && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (!stall) begin
            if (enq_fire) begin
                tail_d = tail_q + PTR_W'(n_enq);
            end
            if (deq_fire) begin
                head_d = head_q + PTR_W'(n_deq);
                err_d  = err_q | over_take;
            end
            count_d = count_q + (enq_fire ? CNT_W'(n_enq) : '0)
                              - (deq_fire ? CNT_W'(n_deq) : '0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (enq_valid[i]) begin
                    mem_q[tail_q + PTR_W'(slot_off[i*OFF_W +: OFF_W])] <=
                        enq_data[i*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            deq_valid[j] = count_q > CNT_W'(j);
            if (deq_valid[j]) begin
                deq_data[j*PAYLOAD_W +: PAYLOAD_W] = mem_q[head_q + PTR_W'(j)];
            end
        end
    end

endmodule

// File: tb/tb_micro_op_queue.sv
// tb/tb_micro_op_queue.sv - self-checking bench for micro_op_queue
module tb_micro_op_queue;
    import micro_op_queue_pkg::*;

    localparam int W = UOP_W;

    logic             clk = 1'b0;
    logic             rstn;
    logic             flush;
    logic             stall;
    logic [3:0]       enq_valid;
    logic [4*W-1:0]   enq_data;
    logic             enq_ready;
    logic [1:0]       deq_valid;
    logic [2*W-1:0]   deq_data;
    logic [1:0]       deq_take;
    logic [4:0]       count;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] mq[$];
    bit           merr;

    micro_op_queue #(
        .ENQ_W     (4),
        .DEQ_W     (2),
        .DEPTH     (16),
        .PAYLOAD_W (W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .stall     (stall),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_take  (deq_take),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       f;
        logic       s;
        logic [3:0] ev;
        logic [1:0] tk;
        logic [4:0] cnt;
        logic [1:0] dv;
        logic       er;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_uop();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic logic [4*W-1:0] rnd_lanes();
        logic [4*W-1:0] d;
        for (int i = 0; i < 4; i++) d[i*W +: W] = rnd_uop();
        return d;
    endfunction

    // Reference view: a plain FIFO of payloads plus a sticky error bit.
    task automatic model_check(input string tag);
        int sz;
        logic [W-1:0] e;
        sz = mq.size();
        chk({tag, ".count"}, 128'(count), 128'(sz));
        chk({tag, ".enq_ready"}, 128'(enq_ready), 128'((16 - sz) >= 4));
        chk({tag, ".err"}, 128'(err), 128'(merr));
        for (int j = 0; j < 2; j++) begin
            e = (j < sz) ? mq[j] : '0;
            chk({tag, ".deq_valid"}, 128'(deq_valid[j]), 128'(j < sz));
            chk({tag, ".deq_data"}, 128'(deq_data[j*W +: W]), 128'(e));
        end
    endtask

    task automatic cyc(input string tag, input logic f, input logic s, input logic [3:0] ev,
                       input logic [1:0] tk, input logic [4*W-1:0] d);
        int sz, avail, n;
        bit rdy;
        flush = f; stall = s; enq_valid = ev; deq_take = tk; enq_data = d;
        sz    = mq.size();
        rdy   = (16 - sz) >= 4;
        avail = (sz < 2) ? sz : 2;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else if (!s) begin
            if (tk != 0) begin
                n = (int'(tk) > avail) ? avail : int'(tk);
                if (int'(tk) > avail) merr = 1'b1;
                repeat (n) void'(mq.pop_front());
            end
            if (rdy && ev != 0) begin
                for (int i = 0; i < 4; i++) if (ev[i]) mq.push_back(d[i*W +: W]);
            end
        end
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic do_reset();
        rstn = 1'b0; flush = 0; stall = 0; enq_valid = 0; deq_take = 0; enq_data = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        mq.delete();
        merr = 1'b0;
        @(negedge clk);
        model_check("reset");
    endtask

    initial begin
        logic [4*W-1:0] d;
        int guard;

        tbl[0] = '{0, 0, 4'b1010, 2'd0, 5'd2, 2'b11, 0};
        tbl[1] = '{0, 0, 4'b0111, 2'd0, 5'd5, 2'b11, 0};
        tbl[2] = '{0, 0, 4'b1101, 2'd2, 5'd6, 2'b11, 0};
        tbl[3] = '{0, 1, 4'b1111, 2'd2, 5'd6, 2'b11, 0};
        tbl[4] = '{0, 0, 4'b0001, 2'd0, 5'd7, 2'b11, 0};
        tbl[5] = '{1, 0, 4'b1111, 2'd2, 5'd0, 2'b00, 0};
        tbl[6] = '{0, 0, 4'b0001, 2'd0, 5'd1, 2'b01, 0};
        tbl[7] = '{0, 0, 4'b0000, 2'd2, 5'd0, 2'b00, 1};
        tbl[8] = '{0, 0, 4'b0000, 2'd0, 5'd0, 2'b00, 1};

        do_reset();

        for (int r = 0; r < 9; r++) begin
            for (int i = 0; i < 4; i++) d[i*W +: W] = W'(32'hC000 + r * 16 + i);
            cyc("tbl", tbl[r].f, tbl[r].s, tbl[r].ev, tbl[r].tk, d);
            chk("tbl.count", 128'(count), 128'(tbl[r].cnt));
            chk("tbl.deq_valid", 128'(deq_valid), 128'(tbl[r].dv));
            chk("tbl.err", 128'(err), 128'(tbl[r].er));
            if (r == 0) begin
                chk("compact.lane0", 128'(deq_data[0 +: W]), 128'(32'hC001));
                chk("compact.lane1", 128'(deq_data[W +: W]), 128'(32'hC003));
            end
            if (r == 2) chk("simul.head", 128'(deq_data[0 +: W]), 128'(32'hC010));
        end

        do_reset();
        chk("reset.err_clear", 128'(err), 128'(0));

        // Fill to full, then drain two per cycle while fetch keeps offering four.
        for (int k = 0; k < 4; k++) cyc("fill", 0, 0, 4'hF, 2'd0, rnd_lanes());
        chk("full.enq_ready", 128'(enq_ready), 128'(0));
        chk("full.count", 128'(count), 128'(16));
        cyc("full.drop", 0, 0, 4'hF, 2'd0, rnd_lanes());
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            cyc("wrap", 0, 0, (guard < 4) ? 4'hF : 4'h0, 2'd2, rnd_lanes());
            chk("wrap.bound", 128'(count <= 5'd16), 128'(1));
            guard++;
        end
        chk("wrap.drained", 128'(guard < 40), 128'(1));

        do_reset();
        for (int k = 0; k < 500; k++) begin
            cyc("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                4'($urandom), 2'($urandom), rnd_lanes());
        end

        // Asynchronous reset landing between edges while an enqueue is pending.
        flush = 0; stall = 0; enq_valid = 4'hF; deq_take = 0; enq_data = rnd_lanes();
        #2 rstn = 1'b0;
        #1;
        chk("async.count", 128'(count), 128'(0));
        chk("async.deq_valid", 128'(deq_valid), 128'(0));
        chk("async.enq_ready", 128'(enq_ready), 128'(1));
        chk("async.err", 128'(err), 128'(0));
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
